// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front end: request FSM states and the buffered entry layout.
package ifetch_pkg;
   localparam int IF_XLEN = 32;
   localparam int IF_ILEN = 32;
   localparam logic [IF_XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef logic [0:0] ifetch_state_e;
   localparam ifetch_state_e IDLE = 1'b0;
   localparam ifetch_state_e REQ  = 1'b1;

   typedef struct packed {
      logic [IF_ILEN-1:0] instr;
      logic [IF_XLEN-1:0] pc;
      logic               fault;
   } ifetch_entry_t;
endpackage

// File: rtl/ifetch_tag_queue.sv
// DEPTH-entry FIFO with synchronous clear, used for PC tags and for the response buffer.
// Write becomes visible at the head the next cycle; the caller never pushes when full or pops when empty.
module ifetch_tag_queue #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: address accepted in N -> imem_req in N+1; rvalid in M -> instr_valid in M+1; pc_ready drops when DEPTH slots are committed.
// IFETCH_ALIGN_CHECK_EN adds instr_fault and turns misaligned PCs into fault entries instead of memory reads.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int XLEN  = IF_XLEN,
   parameter int ILEN  = IF_ILEN,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pc_valid,
   input  logic [XLEN-1:0] pc,
   output logic            pc_ready,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [ILEN-1:0] instruction,
   output logic [XLEN-1:0] instr_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
   output logic            instr_fault,
`endif
   input  logic            instr_ok
);
   localparam int CW = $clog2(DEPTH) + 1;

   ifetch_state_e state;
   logic [XLEN-1:0] addr_q;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   drop_next;
   logic [CW-1:0]   buffered;
   logic [CW-1:0]   tag_count;
   logic [CW:0]     in_use;
   logic            req_dropped;
   logic            credit, misaligned, accept;
   logic            req_live, gnt_live, rsp_any, rsp_drop, rsp_push, fault_push, buf_pop;
   logic [XLEN-1:0] tag_head;
   ifetch_entry_t   buf_in;
   ifetch_entry_t   buf_head;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign in_use = {1'b0, outstanding} + {1'b0, buffered} + (CW+1)'(state == REQ);
   assign credit = in_use < (CW+1)'(DEPTH);
   // A fault entry bypasses memory, so it waits until every older fetch has returned.
   assign pc_ready = rst_n && (state == IDLE) && credit && !flush && (!misaligned || outstanding == '0);
   assign accept   = pc_valid && pc_ready;

   assign req_live   = (state == REQ) && !req_dropped;
   assign gnt_live   = req_live && imem_gnt && !flush;
   assign rsp_any    = imem_rvalid && (drop_cnt != '0 || outstanding != '0);
   assign rsp_drop   = imem_rvalid && (drop_cnt != '0);
   assign rsp_push   = imem_rvalid && (drop_cnt == '0) && (outstanding != '0) && !flush;
   assign fault_push = accept && misaligned;
   assign buf_pop    = instr_valid && instr_ok && !flush;
   assign drop_next  = drop_cnt + outstanding + CW'(req_live) - CW'(rsp_any);

   always_comb begin
      buf_in = '0;
      if (rsp_push) begin
         buf_in.instr = imem_rdata;
         buf_in.pc    = tag_head;
      end else begin
         buf_in.pc    = pc;
         buf_in.fault = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         req_dropped <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (accept && !misaligned) begin
               addr_q <= pc & WORD_MASK;
               state  <= REQ;
            end
         end else if (imem_gnt) begin
            state       <= IDLE;
            req_dropped <= 1'b0;
         end else if (flush) begin
            // The request cannot be retracted; its response is discarded later.
            req_dropped <= 1'b1;
         end

         if (flush) begin
            outstanding <= '0;
            drop_cnt    <= drop_next;
         end else begin
            outstanding <= outstanding + CW'(gnt_live) - CW'(rsp_push);
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   ifetch_tag_queue #(.W(XLEN), .DEPTH(DEPTH)) u_tags (
      .clk(clk), .rst_n(rst_n), .clear(flush),
      .push(gnt_live), .push_data(addr_q), .pop(rsp_push),
      .head(tag_head), .count(tag_count)
   );

   ifetch_tag_queue #(.W($bits(ifetch_entry_t)), .DEPTH(DEPTH)) u_buf (
      .clk(clk), .rst_n(rst_n), .clear(flush),
      .push(rsp_push || fault_push), .push_data(buf_in), .pop(buf_pop),
      .head(buf_head), .count(buffered)
   );

   assign imem_req    = (state == REQ);
   assign imem_addr   = addr_q;
   assign instr_valid = (buffered != '0);
   assign instruction = instr_valid ? buf_head.instr : '0;
   assign instr_pc    = instr_valid ? buf_head.pc : '0;
`ifdef IFETCH_ALIGN_CHECK_EN
   assign instr_fault = instr_valid && buf_head.fault;
`else
   assert property (@(posedge clk) disable iff (!rst_n) !(instr_valid && buf_head.fault));
`endif

   assert property (@(posedge clk) disable iff (!rst_n) !(imem_rvalid && outstanding == '0 && drop_cnt == '0));
   assert property (@(posedge clk) disable iff (!rst_n) tag_count == outstanding);
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised and directed bench for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_valid = 1'b0, flush = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, instr_ok = 1'b0;
   logic [31:0] pc = '0, imem_rdata = '0;
   logic        pc_ready, imem_req, instr_valid;
   logic [31:0] imem_addr, instruction, instr_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
   logic        instr_fault;
`endif

   ifetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
      .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instruction(instruction), .instr_pc(instr_pc),
`ifdef IFETCH_ALIGN_CHECK_EN
      .instr_fault(instr_fault),
`endif
      .instr_ok(instr_ok)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   ent_t        bufq[$];
   logic [31:0] liveq[$];
   logic [31:0] memq[$];
   int          drop_n = 0;
   logic        m_req = 1'b0, m_rdrop = 1'b0;
   logic [31:0] m_addr = '0;
   logic        obs_ready;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
   endfunction

   task automatic model_clear();
      bufq.delete(); liveq.delete(); memq.delete();
      drop_n = 0; m_req = 1'b0; m_rdrop = 1'b0; m_addr = '0;
   endtask

   // One clock cycle: drive at negedge, check settled outputs, advance model at posedge.
   task automatic cyc(input logic pv, input logic [31:0] a, input logic fl,
                      input logic gnt, input logic rv, input logic ok);
      logic exp_rdy, mis, seen_req, rv_now;
      logic [31:0] seen_addr, rd;
      int used, consumed;
      ent_t e;
      pc_valid = pv; pc = a; flush = fl; imem_gnt = gnt; instr_ok = ok;
      imem_rvalid = rv && (memq.size() > 0);
      imem_rdata  = imem_rvalid ? mem_data(memq[0]) : 32'h0;
      #1;
      used = liveq.size() + bufq.size() + (m_req ? 1 : 0);
      mis = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      mis = (a[1:0] != 2'b00);
`endif
      exp_rdy = !m_req && (used < DEPTH) && !fl && (!mis || liveq.size() == 0);
      check_eq("pc_ready", 32'(pc_ready), 32'(exp_rdy));
      check_eq("imem_req", 32'(imem_req), 32'(m_req));
      check_eq("imem_addr", imem_addr, m_addr);
      check_eq("instr_valid", 32'(instr_valid), 32'(bufq.size() > 0));
      check_eq("instruction", instruction, (bufq.size() > 0) ? bufq[0].instr : 32'h0);
      check_eq("instr_pc", instr_pc, (bufq.size() > 0) ? bufq[0].pc : 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
      check_eq("instr_fault", 32'(instr_fault), 32'((bufq.size() > 0) && bufq[0].fault));
`endif
      obs_ready = pc_ready; seen_req = imem_req; seen_addr = imem_addr;
      rv_now = imem_rvalid; rd = imem_rdata;
      @(posedge clk);
      if (rv_now) void'(memq.pop_front());
      if (seen_req && gnt) memq.push_back(seen_addr);
      if (fl) begin
         consumed = (rv_now && (drop_n > 0 || liveq.size() > 0)) ? 1 : 0;
         drop_n = drop_n + liveq.size() + ((m_req && !m_rdrop) ? 1 : 0) - consumed;
         liveq.delete(); bufq.delete();
         if (m_req) begin
            if (gnt) begin m_req = 1'b0; m_rdrop = 1'b0; end
            else m_rdrop = 1'b1;
         end
      end else begin
         if (ok && bufq.size() > 0) void'(bufq.pop_front());
         if (rv_now) begin
            if (drop_n > 0) drop_n--;
            else if (liveq.size() > 0) begin
               e.instr = rd; e.pc = liveq.pop_front(); e.fault = 1'b0;
               bufq.push_back(e);
            end
         end
         if (m_req) begin
            if (gnt) begin
               if (!m_rdrop) liveq.push_back(m_addr);
               m_req = 1'b0; m_rdrop = 1'b0;
            end
         end else if (pv && exp_rdy) begin
            if (mis) begin
               e.instr = 32'h0; e.pc = a; e.fault = 1'b1;
               bufq.push_back(e);
            end else begin
               m_req = 1'b1;
               m_addr = {a[31:2], 2'b00};
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ok = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      check_eq("rst_pc_ready", 32'(pc_ready), 32'h0);
      check_eq("rst_imem_req", 32'(imem_req), 32'h0);
      check_eq("rst_imem_addr", imem_addr, 32'h0);
      check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
      check_eq("rst_instruction", instruction, 32'h0);
      check_eq("rst_instr_pc", instr_pc, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
      check_eq("rst_instr_fault", 32'(instr_fault), 32'h0);
`endif
      model_clear();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] rpc;
      @(negedge clk);
      do_reset();

      // Idle after reset, then a single fetch with a two-cycle memory latency
      cyc(0, 32'h0, 0, 0, 0, 0);
      check_eq("idle_ready", 32'(obs_ready), 32'h1);
      cyc(1, 32'h100, 0, 1, 0, 0);
      check_eq("t2_req", 32'(imem_req), 32'h1);
      cyc(0, 32'h0, 0, 1, 0, 0);
      cyc(0, 32'h0, 0, 0, 0, 0);
      cyc(0, 32'h0, 0, 0, 1, 0);
      check_eq("t2_instr", instruction, 32'h13);
      check_eq("t2_pc", instr_pc, 32'h100);
      cyc(0, 32'h0, 0, 0, 0, 1);

      // Backpressure: four fetches fill every credit
      for (int i = 0; i < 4; i++) begin
         cyc(1, 32'(i * 4), 0, 1, 0, 0);
         cyc(0, 32'h0, 0, 1, 0, 0);
      end
      cyc(1, 32'h10, 0, 0, 0, 0);
      check_eq("t3_full_ready", 32'(obs_ready), 32'h0);
      for (int i = 0; i < 4; i++) cyc(0, 32'h0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         check_eq("t3_order_pc", instr_pc, 32'(i * 4));
         cyc(0, 32'h0, 0, 0, 0, 1);
      end

      // Flush with two outstanding fetches
      cyc(1, 32'h20, 0, 1, 0, 0); cyc(0, 32'h0, 0, 1, 0, 0);
      cyc(1, 32'h24, 0, 1, 0, 0); cyc(0, 32'h0, 0, 1, 0, 0);
      cyc(0, 32'h0, 1, 0, 0, 0);
      cyc(0, 32'h0, 0, 0, 1, 0);
      check_eq("t4_drop0", 32'(instr_valid), 32'h0);
      cyc(0, 32'h0, 0, 0, 1, 0);
      check_eq("t4_drop1", 32'(instr_valid), 32'h0);
      cyc(1, 32'h40, 0, 1, 0, 0); cyc(0, 32'h0, 0, 1, 0, 0);
      cyc(0, 32'h0, 0, 0, 1, 0);
      check_eq("t4_after_instr", instruction, mem_data(32'h40));
      check_eq("t4_after_pc", instr_pc, 32'h40);
      cyc(0, 32'h0, 0, 0, 0, 1);

      // Grant stall
      cyc(1, 32'h80, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check_eq("t5_req", 32'(imem_req), 32'h1);
         check_eq("t5_addr", imem_addr, 32'h80);
         cyc(0, 32'h0, 0, 0, 0, 0);
      end
      cyc(0, 32'h0, 0, 1, 0, 0);
      check_eq("t5_one_tag", 32'(memq.size()), 32'h1);
      cyc(0, 32'h0, 0, 0, 1, 0);
      check_eq("t5_pc", instr_pc, 32'h80);
      cyc(0, 32'h0, 0, 0, 0, 1);

      // Misaligned PC
      cyc(1, 32'h102, 0, 0, 0, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
      check_eq("t6_no_req", 32'(imem_req), 32'h0);
      check_eq("t6_fault", 32'(instr_fault), 32'h1);
      check_eq("t6_pc", instr_pc, 32'h102);
      cyc(0, 32'h0, 0, 0, 0, 1);
`else
      check_eq("t6_addr", imem_addr, 32'h100);
      cyc(0, 32'h0, 0, 1, 0, 0);
      cyc(0, 32'h0, 0, 0, 1, 0);
      check_eq("t6_pc", instr_pc, 32'h100);
      cyc(0, 32'h0, 0, 0, 0, 1);
`endif

      // Random traffic: memory latency kept short so in-flight reads stay bounded
      for (int i = 0; i < 3000; i++) begin
         rpc = 32'($urandom_range(0, 1023));
`ifdef IFETCH_ALIGN_CHECK_EN
         if ($urandom % 4 != 0) rpc[1:0] = 2'b00;
`endif
         cyc(1'($urandom % 2), rpc, 1'($urandom % 16 == 0), 1'($urandom % 4 != 0),
             1'((memq.size() >= 4) || ($urandom % 4 != 0)), 1'($urandom % 3 != 0));
      end
      for (int i = 0; i < 20; i++) cyc(0, 32'h0, 0, 1, 1, 1);

      // Reset in the middle of a pending request
      cyc(1, 32'h200, 0, 0, 0, 0);
      cyc(0, 32'h0, 0, 0, 0, 0);
      do_reset();
      cyc(0, 32'h0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
